// File: rtl/fb_pkg.sv
// Shared types and constants for the text framebuffer reader.
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_EOL,
    ST_DONE
  } fb_state_e;

  localparam logic [7:0] FB_BASE_DEF = 8'hC0;
  localparam logic [7:0] CHAR_NL     = 8'h0A;
  localparam logic [7:0] CHAR_DOT    = 8'h2E;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

endpackage

// File: rtl/fb_frame_tick.sv
// Free-running frame period counter; tick_o marks its last count.
module fb_frame_tick #(
  parameter int unsigned FRAME_PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(FRAME_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(FRAME_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fb_text_reader.sv
// Scans the text framebuffer and streams it out row by row with newlines.
// Define FB_NONPRINT_FILTER_EN to replace non-printable bytes with '.'.
module fb_text_reader
  import fb_pkg::*;
#(
  parameter logic [7:0]  FB_BASE      = FB_BASE_DEF,
  parameter int unsigned FB_COLS      = 16,
  parameter int unsigned FB_ROWS      = 4,
  parameter int unsigned FRAME_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_gnt,
  input  logic [7:0] mem_rdata,
  output logic       char_valid,
  output logic [7:0] char_data,
  input  logic       char_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_overrun
);

  localparam int CW = (FB_COLS > 1) ? $clog2(FB_COLS) : 1;
  localparam int RW = (FB_ROWS > 1) ? $clog2(FB_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FB_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FB_ROWS - 1);

  fb_state_e     state_q, state_d;
  logic [7:0]    ptr_q, ptr_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    char_q, char_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;

  logic          req_q, req_d;
  logic [7:0]    addr_q, addr_d;
  logic          val_q, val_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic       tick;
  logic       trig;
  logic [7:0] fetched;

  fb_frame_tick #(
    .FRAME_PERIOD(FRAME_PERIOD)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  assign trig = tick | frame_start;

`ifdef FB_NONPRINT_FILTER_EN
  assign fetched = (mem_rdata < PRINT_LO || mem_rdata > PRINT_HI)
                 ? CHAR_DOT : mem_rdata;
`else
  assign fetched = mem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    row_d   = row_q;
    char_d  = char_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;

    // A second queued trigger cannot be honoured; record it.
    if (trig && state_q != ST_IDLE) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (trig || pend_q) begin
          pend_d  = 1'b0;
          ptr_d   = FB_BASE;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_gnt) begin
          char_d  = fetched;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (char_ready) begin
          ptr_d = ptr_q + 8'd1;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_EOL;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_EOL: begin
        if (char_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d  = 1'b0;
    addr_d = '0;
    val_d  = 1'b0;
    data_d = '0;
    done_d = 1'b0;
    unique case (1'b1)
      state_d == ST_FETCH: begin
        req_d  = 1'b1;
        addr_d = ptr_d;
      end
      state_d == ST_EMIT: begin
        val_d  = 1'b1;
        data_d = char_d;
      end
      state_d == ST_EOL: begin
        val_d  = 1'b1;
        data_d = CHAR_NL;
      end
      state_d == ST_DONE: done_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= FB_BASE;
      col_q   <= '0;
      row_q   <= '0;
      char_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      val_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      char_q  <= char_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_req       = req_q;
  assign mem_addr      = addr_q;
  assign char_valid    = val_q;
  assign char_data     = data_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_fb_text_reader.sv
// Scoreboard bench for fb_text_reader: directed frames, backpressure,
// periodic trigger, overrun, mid-frame reset and the non-printable filter.
module tb_fb_text_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       mem_gnt = 1'b0;
  logic       char_ready = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       char_valid;
  logic [7:0] char_data;
  logic       busy;
  logic       frame_done;
  logic       frame_overrun;

  logic [7:0] mem [256];
  logic [7:0] expq [$];
  logic [7:0] filt_exp [3];
  bit         filt_on = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rel = 0;
  int st_cyc = 0;
  int req_cyc = -1;
  int done_cyc = -1;
  int done_cnt = 0;
  int acc_cnt = 0;
  int mode = 0;
  int dly = 0;
  int d1;
  logic [7:0] req_addr = '0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  fb_text_reader dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rdata    (mem_rdata),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .char_ready   (char_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_overrun(frame_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ev);
    n_cmp++;
    if (act !== ev) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, ev);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // 0: grant/ready high, 1: random stalls, 2: grant high, ready low
  always @(negedge clk) begin
    if (mode == 0) begin
      mem_gnt    = 1'b1;
      char_ready = 1'b1;
    end else if (mode == 1) begin
      char_ready = 1'($urandom_range(0, 1));
      if (mem_req && dly == 0) begin
        mem_gnt = 1'b1;
      end else begin
        mem_gnt = 1'b0;
        if (mem_req) dly--;
        else         dly = $urandom_range(0, 3);
      end
    end else begin
      mem_gnt    = 1'b1;
      char_ready = 1'b0;
    end
  end

  logic       p_req = 1'b0, p_gnt = 1'b0, p_val = 1'b0, p_rdy = 1'b0;
  logic [7:0] p_addr = '0, p_dat = '0;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      p_req = 1'b0;
      p_val = 1'b0;
    end else begin
      if (mem_req || char_valid)
        chk("req_valid_excl", 32'(mem_req & char_valid), 0);
      if (p_req && !p_gnt)
        chk("addr_stable", {mem_req, mem_addr}, {1'b1, p_addr});
      if (p_val && !p_rdy)
        chk("data_stable", {char_valid, char_data}, {1'b1, p_dat});
      if (char_valid && char_ready) begin
        acc_cnt++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none",
                   char_data);
        end else begin
          chk("stream_byte", char_data, expq.pop_front());
        end
      end
      if (mem_req && req_cyc < 0) begin
        req_cyc  = cyc;
        req_addr = mem_addr;
      end
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      p_req  = mem_req;
      p_gnt  = mem_gnt;
      p_addr = mem_addr;
      p_val  = char_valid;
      p_rdy  = char_ready;
      p_dat  = char_data;
    end
  end

  task automatic push_frame();
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = mem[8'hC0 + 8'(i)];
      if (filt_on && i < 3) b = filt_exp[i];
      expq.push_back(b);
      if (i % 16 == 15) expq.push_back(8'h0A);
    end
  endtask

  task automatic clear_marks();
    req_cyc  = -1;
    done_cyc = -1;
    done_cnt = 0;
    acc_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    clear_marks();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int i = 0;
    while (done_cnt < n && i < budget) begin
      @(negedge clk);
      #3;
      i++;
    end
    chk(nm, 32'(done_cnt >= n), 1);
  endtask

  task automatic wait_req(input int budget, input string nm);
    int i = 0;
    while (req_cyc < 0 && i < budget) begin
      @(negedge clk);
      #3;
      i++;
    end
    chk(nm, 32'(req_cyc >= 0), 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) mem[8'hC0 + 8'(i)] = 8'h41 + 8'(i % 26);
`ifdef FB_NONPRINT_FILTER_EN
    filt_exp[0] = 8'h2E;
    filt_exp[1] = 8'h2E;
`else
    filt_exp[0] = 8'h07;
    filt_exp[1] = 8'h7F;
`endif
    filt_exp[2] = 8'h7E;

    @(negedge clk);
    #2;
    chk("reset_outputs", {mem_req, mem_addr, char_valid, char_data,
        busy, frame_done, frame_overrun}, 0);

    // Basic frame with everything ready
    mode = 0;
    do_reset();
    #2;
    chk("idle_outputs", {mem_req, mem_addr, char_valid, char_data,
        busy, frame_done, frame_overrun}, 0);
    push_frame();
    pulse_start();
    wait_done(1, 400, "basic_done_timeout");
    chk("req_latency", 32'(req_cyc - st_cyc), 1);
    chk("first_addr", req_addr, 8'hC0);
    // DONE is the 133rd cycle of the frame, 132 edges after the first request
    chk("done_latency", 32'(done_cyc - req_cyc), 132);
    chk("basic_bytes", acc_cnt, 68);
    chk("basic_queue", expq.size(), 0);
    chk("basic_overrun", frame_overrun, 0);

    // Random ready and delayed grant
    mode = 1;
    do_reset();
    push_frame();
    pulse_start();
    wait_done(1, 3000, "bp_done_timeout");
    chk("bp_bytes", acc_cnt, 68);
    chk("bp_queue", expq.size(), 0);

    // Periodic trigger only
    mode = 0;
    do_reset();
    push_frame();
    push_frame();
    wait_req(300, "tick1_timeout");
    chk("tick_first_req", 32'(req_cyc - rel), 256);
    wait_done(1, 300, "tick1_done_timeout");
    req_cyc = -1;
    wait_req(300, "tick2_timeout");
    chk("tick_second_req", 32'(req_cyc - rel), 512);
    wait_done(2, 300, "tick2_done_timeout");
    chk("tick_overrun", frame_overrun, 0);
    chk("tick_queue", expq.size(), 0);

    // Overrun while stalled
    mode = 2;
    do_reset();
    push_frame();
    push_frame();
    pulse_start();
    repeat (4) @(negedge clk);
    chk("stalled_busy", busy, 1);
    pulse_start();
    #2;
    chk("ovr_pending_only", frame_overrun, 0);
    pulse_start();
    #2;
    chk("ovr_set", frame_overrun, 1);
    repeat (5) @(negedge clk);
    mode = 0;
    wait_done(1, 400, "ovr_done1_timeout");
    d1 = done_cyc;
    req_cyc = -1;
    wait_req(10, "ovr_req2_timeout");
    chk("back_to_back", 32'(req_cyc - d1), 2);
    wait_done(2, 400, "ovr_done2_timeout");
    chk("ovr_bytes", acc_cnt, 136);
    chk("ovr_queue", expq.size(), 0);
    chk("ovr_sticky", frame_overrun, 1);

    // Reset in the middle of a frame
    mode = 0;
    do_reset();
    push_frame();
    pulse_start();
    for (int i = 0; i < 100 && acc_cnt < 10; i++) begin
      @(negedge clk);
      #3;
    end
    chk("midrst_progress", 32'(acc_cnt >= 10), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {mem_req, mem_addr, char_valid, char_data,
        busy, frame_done, frame_overrun}, 0);
    expq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_marks();
    repeat (3) @(negedge clk);
    #3;
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", busy, 0);
    push_frame();
    pulse_start();
    wait_req(10, "midrst_req_timeout");
    chk("restart_addr", req_addr, 8'hC0);
    wait_done(1, 400, "midrst_done_timeout");
    chk("midrst_queue", expq.size(), 0);

    // Non-printable bytes
    do_reset();
    mem[8'hC0] = 8'h07;
    mem[8'hC1] = 8'h7F;
    mem[8'hC2] = 8'h7E;
    filt_on = 1'b1;
    push_frame();
    pulse_start();
    wait_done(1, 400, "filt_done_timeout");
    chk("filt_queue", expq.size(), 0);
    filt_on = 1'b0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, expected summary");
    $fatal(1);
  end

endmodule
